// File: rtl/ddr_dimm_responder_if.sv
// rtl/ddr_dimm_responder_if.sv - DDR4 command/data bus between controller (master) and DIMM responder (slave)
interface ddr_dimm_responder_if #(
    parameter int BANKS = 16,
    parameter int DQ_W  = 8
);
    logic             cs_n;
    logic             act_n;
    logic             ras_n_a16;
    logic             cas_n_a15;
    logic             we_n_a14;
    logic [1:0]       bg;
    logic [1:0]       ba;
    logic [13:0]      addr;
    logic [5:0]       rd_lat;
    logic [5:0]       wr_lat;
    logic [DQ_W-1:0]  dq_in;
    logic [DQ_W-1:0]  dq_out;
    logic             dq_oe;
    logic             dqs_out;
    logic [BANKS-1:0] bank_open;
    logic             err_cmd;
    logic [2:0]       err_code;

    modport master (
        output cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, addr, rd_lat, wr_lat, dq_in,
        input  dq_out, dq_oe, dqs_out, bank_open, err_cmd, err_code
    );

    modport slave (
        input  cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, addr, rd_lat, wr_lat, dq_in,
        output dq_out, dq_oe, dqs_out, bank_open, err_cmd, err_code
    );
endinterface

// File: rtl/ddr_dimm_responder.sv
// rtl/ddr_dimm_responder.sv - DDR4 DIMM-side responder: command decode, bank tracking, latency queue, BL8 bursts
module ddr_dimm_responder #(
    parameter int BANKS  = 16,
    parameter int DQ_W   = 8,
    parameter int MEM_AW = 13,
    parameter int QDEPTH = 4
) (
    input  logic                clock_n,
    input  logic                reset_n,
    ddr_dimm_responder_if.slave bus
);
    localparam int BW = 8 * DQ_W;
    localparam int QW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

    state_t           state, state_nx;
    logic [2:0]       beat;
    logic [BANKS-1:0] open_q;
    logic [1:0]       row_lo [BANKS];
    logic             err_q;
    logic [2:0]       code_q;

    logic              q_rw  [QDEPTH];
    logic [MEM_AW-1:0] q_idx [QDEPTH];
    logic [5:0]        q_cd  [QDEPTH];
    logic [QW-1:0]     q_cnt;
    logic              n_rw  [QDEPTH];
    logic [MEM_AW-1:0] n_idx [QDEPTH];
    logic [5:0]        n_cd  [QDEPTH];
    logic [QW-1:0]     n_cnt;

    logic [BW-1:0]     mem [0:(1<<MEM_AW)-1];
    logic [BW-1:0]     rword;
    logic [BW-1:0]     wstage;
    logic [MEM_AW-1:0] w_idx;

    logic [3:0]        bank;
    logic [2:0]        cmd;
    logic              sel, is_act, is_mrs_ref, is_pre, is_rd, is_wr, is_rw;
    logic              hit, full, push, head_due, engine_free, start;
    logic [5:0]        lat, cd_new;
    logic [12:0]       idx_full;
    logic [MEM_AW-1:0] push_idx;
    logic [2:0]        code_nx;
    logic              unused_bits;

    assign bank        = {bus.bg, bus.ba};
    assign cmd         = {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14};
    assign sel         = !bus.cs_n;
    assign is_act      = sel && !bus.act_n;
    assign is_mrs_ref  = sel && bus.act_n && (cmd == 3'b000 || cmd == 3'b001);
    assign is_pre      = sel && bus.act_n && (cmd == 3'b010);
    assign is_wr       = sel && bus.act_n && (cmd == 3'b100);
    assign is_rd       = sel && bus.act_n && (cmd == 3'b101);
    assign is_rw       = is_rd || is_wr;
    assign hit         = open_q[bank];
    assign full        = (q_cnt == QW'(QDEPTH));
    assign push        = is_rw && hit && !full;
    assign lat         = is_rd ? bus.rd_lat : bus.wr_lat;
    assign cd_new      = (lat == 6'd0) ? 6'd0 : lat - 6'd1;
    // col[2:0] dropped: bursts are always 8-beat aligned
    assign idx_full    = {bank, row_lo[bank], bus.addr[9:3]};
    assign push_idx    = idx_full[MEM_AW-1:0];
    assign head_due    = (q_cnt != '0) && (q_cd[0] == 6'd0);
    assign engine_free = (state == IDLE) || (beat == 3'd7);
    assign start       = head_due && engine_free;
    assign unused_bits = ^{bus.addr[13:11], bus.addr[2], wstage[BW-1 -: DQ_W]};

    always_comb begin
        code_nx = 3'd0;
        if (is_act && hit)                  code_nx = 3'd1;
        else if (is_rw && !hit)             code_nx = 3'd2;
        else if (is_mrs_ref && (|open_q))   code_nx = 3'd3;
        else if (is_rw && full)             code_nx = 3'd4;
        else if (head_due && !engine_free)  code_nx = 3'd5;
    end

    // Every entry ages each cycle; the head leaves when due, whether it starts a burst or is discarded
    always_comb begin
        n_cnt = q_cnt;
        for (int i = 0; i < QDEPTH; i++) begin
            n_rw[i]  = q_rw[i];
            n_idx[i] = q_idx[i];
            n_cd[i]  = (q_cd[i] == 6'd0) ? 6'd0 : q_cd[i] - 6'd1;
        end
        if (head_due) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                n_rw[i]  = n_rw[i+1];
                n_idx[i] = n_idx[i+1];
                n_cd[i]  = n_cd[i+1];
            end
            n_cnt = q_cnt - QW'(1);
        end
        if (push) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (QW'(i) == n_cnt) begin
                    n_rw[i]  = is_wr;
                    n_idx[i] = push_idx;
                    n_cd[i]  = cd_new;
                end
            end
            n_cnt = n_cnt + QW'(1);
        end
    end

    always_ff @(posedge clock_n or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            beat  <= 3'd0;
        end else begin
            state <= state_nx;
            beat  <= (start || state == IDLE) ? 3'd0 : beat + 3'd1;
        end
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && beat == 3'd7) state_nx = IDLE;
        if (start)                         state_nx = q_rw[0] ? WBURST : RBURST;
    end

    always_comb begin
        bus.dq_oe     = (state == RBURST);
        bus.dqs_out   = (state == RBURST) && beat[0];
        bus.dq_out    = (state == RBURST) ? rword[beat*DQ_W +: DQ_W] : '0;
        bus.bank_open = open_q;
        bus.err_cmd   = err_q;
        bus.err_code  = code_q;
    end

    always_ff @(posedge clock_n or negedge reset_n) begin
        if (!reset_n) begin
            open_q <= '0;
            err_q  <= 1'b0;
            code_q <= 3'd0;
            q_cnt  <= '0;
            for (int i = 0; i < BANKS; i++) row_lo[i] <= 2'd0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_rw[i]  <= 1'b0;
                q_idx[i] <= '0;
                q_cd[i]  <= 6'd0;
            end
        end else begin
            err_q  <= (code_nx != 3'd0);
            code_q <= code_nx;
            q_cnt  <= n_cnt;
            for (int i = 0; i < QDEPTH; i++) begin
                q_rw[i]  <= n_rw[i];
                q_idx[i] <= n_idx[i];
                q_cd[i]  <= n_cd[i];
            end
            if (is_act) begin
                open_q[bank] <= 1'b1;
                row_lo[bank] <= bus.addr[1:0];
            end
            if (is_pre) begin
                if (bus.addr[10]) open_q       <= '0;
                else              open_q[bank] <= 1'b0;
            end
            if (push && bus.addr[10]) open_q[bank] <= 1'b0;
        end
    end

    // Storage survives reset; a write burst cut by reset never reaches beat 7 so it is never committed
    always_ff @(posedge clock_n) begin
        if (start) begin
            w_idx <= q_idx[0];
            rword <= mem[q_idx[0]];
        end
        if (state == WBURST) begin
            wstage[beat*DQ_W +: DQ_W] <= bus.dq_in;
            if (beat == 3'd7) mem[w_idx] <= {bus.dq_in, wstage[BW-DQ_W-1:0]};
        end
    end
endmodule
